// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - EX operand forwarding selects and load-use stall control
// Optional WB bypass select (11) is enabled by defining FWD_WB_BYPASS_EN.
module fwd_ctrl #(
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [REG_AW-1:0]      id_rs1_i,
  input  logic [REG_AW-1:0]      id_rs2_i,
  input  logic                   id_rs1_used_i,
  input  logic                   id_rs2_used_i,
  input  logic [REG_AW-1:0]      id_rd_i,
  input  logic                   id_regwrite_i,
  input  logic                   id_memread_i,
  input  logic                   flush_i,
  output logic [1:0]             fwd_a_o,
  output logic [1:0]             fwd_b_o,
  output logic                   stall_o,
  output logic                   pc_write_o,
  output logic                   ifid_write_o,
  output logic                   idex_bubble_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  logic              r_ex_valid, r_ex_regwrite, r_ex_memread;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_mem_valid, r_mem_regwrite;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_wb_valid, r_wb_regwrite;
  logic [REG_AW-1:0] r_wb_rd;

  logic [1:0]             r_fwd_a, r_fwd_b;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic       w_load_hit, w_stall, w_bubble;
  logic [1:0] w_sel_a, w_sel_b;

  // Stage ages map to mux inputs: EX producer -> ALU result, MEM -> writeback, WB -> bypass reg.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] rs);
    fwd_sel = 2'b00;
    if (used && rs != '0) begin
      if (r_ex_valid && r_ex_regwrite && r_ex_rd == rs)
        fwd_sel = 2'b10;
      else if (r_mem_valid && r_mem_regwrite && r_mem_rd == rs)
        fwd_sel = 2'b01;
`ifdef FWD_WB_BYPASS_EN
      else if (r_wb_valid && r_wb_regwrite && r_wb_rd == rs)
        fwd_sel = 2'b11;
`endif
    end
  endfunction

  always_comb begin
    w_sel_a = fwd_sel(id_rs1_used_i, id_rs1_i);
    w_sel_b = fwd_sel(id_rs2_used_i, id_rs2_i);
  end

  assign w_load_hit = r_ex_valid && r_ex_memread && (r_ex_rd != '0) &&
                      ((id_rs1_used_i && id_rs1_i == r_ex_rd) ||
                       (id_rs2_used_i && id_rs2_i == r_ex_rd));
  assign w_stall    = w_load_hit && !flush_i;
  assign w_bubble   = w_stall || flush_i;

`ifndef FWD_WB_BYPASS_EN
  logic w_unused_wb;
  assign w_unused_wb = ^{r_wb_valid, r_wb_regwrite, r_wb_rd};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ex_valid     <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_rd        <= '0;
      r_mem_valid    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_rd       <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_rd        <= '0;
      r_fwd_a        <= 2'b00;
      r_fwd_b        <= 2'b00;
      r_stall_cnt    <= '0;
    end else begin
      r_wb_valid     <= r_mem_valid;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_rd        <= r_mem_rd;
      r_mem_valid    <= r_ex_valid;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_rd       <= r_ex_rd;
      r_ex_valid     <= !w_bubble;
      r_ex_regwrite  <= id_regwrite_i;
      r_ex_memread   <= id_memread_i;
      r_ex_rd        <= id_rd_i;
      r_fwd_a        <= w_bubble ? 2'b00 : w_sel_a;
      r_fwd_b        <= w_bubble ? 2'b00 : w_sel_b;
      if (w_stall && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign fwd_a_o       = r_fwd_a;
  assign fwd_b_o       = r_fwd_b;
  assign stall_o       = w_stall;
  assign pc_write_o    = !w_stall;
  assign ifid_write_o  = !w_stall;
  assign idex_bubble_o = w_bubble;
  assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding and load-use hazard controller for the 5-stage pipeline. It tracks the destination register and write/load attributes of the instructions in EX, MEM and WB. It produces the registered 2-bit selects for the two EX-stage operand 4:1 32-bit muxes and the load-use stall/bubble controls for PC, IF/ID and ID/EX. It sits beside the ID/EX pipeline register and sequences the operand muxes; it owns no data path.

## Interface
- REG_AW, 5, register address width
- STALL_CNT_W, 16, width of stall-cycle counter
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- id_rs1_i  in  REG_AW  rs1 of instruction in ID
- id_rs2_i  in  REG_AW  rs2 of instruction in ID
- id_rs1_used_i / id_rs2_used_i  in  1  operand actually read
- id_rd_i  in  REG_AW  rd of instruction in ID
- id_regwrite_i  in  1  ID instruction writes rd
- id_memread_i  in  1  ID instruction is a load
- flush_i  in  1  taken branch/jump: ID instruction must not enter EX
- fwd_a_o  out  2  EX operand A mux select
- fwd_b_o  out  2  EX operand B mux select
- stall_o  out  1  load-use hazard this cycle
- pc_write_o  out  1  ~stall_o
- ifid_write_o  out  1  ~stall_o
- idex_bubble_o  out  1  stall_o | flush_i
- stall_cnt_o  out  STALL_CNT_W  saturating count of stall cycles

## Operation
- Internal stages EX, MEM, WB. Each holds {valid, rd, regwrite}; EX also holds memread. Every clock: WB<=MEM, MEM<=EX, EX<=ID inputs. When idex_bubble_o=1, EX is loaded with valid=0 instead.
- Select encoding follows mux input order:
  - 00 register-file value from ID/EX
  - 01 MEM/WB writeback data
  - 10 EX/MEM ALU result
  - 11 WB bypass (only when the macro is enabled, see Configuration)
- Select for the instruction entering EX, operand rsN with used=1 and rsN!=0, checked in priority order:
  1. EX.valid & EX.regwrite & EX.rd==rsN -> 10
  2. else MEM.valid & MEM.regwrite & MEM.rd==rsN -> 01
  3. else 00
- Register x0 is never forwarded. When the operand's used flag is 0, the select is 00.
- Load-use detection: stall_o = EX.valid & EX.memread & EX.rd!=0 & ((rs1_used & rs1==EX.rd) | (rs2_used & rs2==EX.rd)) & ~flush_i.
- On stall, ID holds its instruction, and the next cycle re-evaluates with the load now in MEM. The consumer then receives select 01.
- flush_i has priority over stall: stall_o=0, bubble=1.
- stall_cnt_o increments on every cycle with stall_o=1 and saturates at all-ones.

## Timing
- fwd_a_o and fwd_b_o are registered. They update on the edge on which the instruction enters EX and are stable for that whole EX cycle. With a bubble, they load 00.
- stall_o, pc_write_o, ifid_write_o and idex_bubble_o are combinational from current state and inputs, with zero latency.
- Reset (asynchronous): all stage valid bits=0, fwd_a_o=fwd_b_o=00, stall_cnt_o=0. Hence stall_o=0, pc_write_o=1, ifid_write_o=1, idex_bubble_o=flush_i.
- Reset mid-stall drops the stall immediately. The pending load is discarded.
- Back-to-back loads to the same rd: at most one stall cycle per consumer.

## Configuration
- FWD_WB_BYPASS_EN defined:
  - adds a check after the MEM check: WB.valid & WB.regwrite & WB.rd==rsN -> 11 (WB bypass holding register).
  - The register file then needs no internal write-before-read.
- Not defined:
  - 11 is never produced.
  - The WB stage is tracked only for pipeline advance, and the register file must bypass its same-cycle write.

## Test plan
- Reset with flush_i=0 -> fwd_a_o=fwd_b_o=00, stall_o=0, pc_write_o=1, stall_cnt_o=0.
- add x5 followed immediately by sub using rs1=x5 -> fwd_a_o=10 during the sub's EX cycle. A second consumer one instruction later gets 01.
- lw x7 followed by add using rs2=x7 -> exactly one cycle of stall_o=1 with idex_bubble_o=1. The add then enters EX with fwd_b_o=01, and stall_cnt_o=1.
- Write to x0 followed by a consumer of x0 -> selects stay 00 and no stall, even after a load to x0.
- Load-use hazard asserted together with flush_i=1 -> stall_o=0, idex_bubble_o=1, stall_cnt_o unchanged.
- With FWD_WB_BYPASS_EN: producer, two independent instructions, then consumer -> select 11. Without the macro, the same sequence gives 00.
